// File: rtl/demux1to4_stream_if.sv
// Stream bundle for demux1to4_stream: one tagged input stream, four output streams.
// The in_bcast signal only exists in builds with DEMUX_BCAST_EN.
interface demux1to4_stream_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_sel;
    logic [WIDTH-1:0]   in_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
`ifdef DEMUX_BCAST_EN
    logic               in_bcast;

    modport master (
        output in_valid, in_sel, in_data, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_sel, in_data, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );
`else
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/demux1to4_stream.sv
// Buffered 1-to-4 stream demux: in_sel steers each word into a per-channel FIFO.
// Define DEMUX_BCAST_EN to add in_bcast, which copies one word into all four FIFOs.
module demux1to4_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux1to4_stream_if.slave    bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [3:0]            full;
    logic [3:0]            empty;
    logic [3:0]            push;
    logic [3:0]            pop;
    logic [3:0]            sel_hit;
    logic [3:0][WIDTH-1:0] head;
    logic                  accept;

`ifdef DEMUX_BCAST_EN
    // A broadcast needs room everywhere, so in_sel plays no part.
    assign bus.in_ready = bus.in_bcast ? ~|full : !full[bus.in_sel];
`else
    assign bus.in_ready = !full[bus.in_sel];
`endif

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_ready & ~empty;

    always_comb begin
        sel_hit             = 4'b0000;
        sel_hit[bus.in_sel] = 1'b1;
        push                = 4'b0000;
        if (accept) begin
`ifdef DEMUX_BCAST_EN
            push = bus.in_bcast ? 4'b1111 : sel_hit;
`else
            push = sel_hit;
`endif
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [AW-1:0]    wr_q, wr_d;
        logic [AW-1:0]    rd_q, rd_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic [WIDTH-1:0] mem_q [DEPTH];

        always_comb begin
            wr_d  = wr_q;
            rd_d  = rd_q;
            cnt_d = cnt_q;
            if (push[k]) wr_d = wr_q + AW'(1);
            if (pop[k])  rd_d = rd_q + AW'(1);
            if (push[k] && !pop[k])
                cnt_d = cnt_q + CW'(1);
            else if (!push[k] && pop[k])
                cnt_d = cnt_q - CW'(1);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
            end
        end

        // Storage needs no reset: an empty channel masks its head to zero.
        always_ff @(posedge clk) begin
            if (push[k]) mem_q[wr_q] <= bus.in_data;
        end

        assign full[k]  = (cnt_q == FULL_CNT);
        assign empty[k] = (cnt_q == '0);
        assign head[k]  = empty[k] ? '0 : mem_q[rd_q];
    end

    assign bus.out_valid = ~empty;
    assign bus.out_data  = head;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed bench for demux1to4_stream, hand-computed expectations.
// The broadcast section is compiled only with DEMUX_BCAST_EN.
module tb_demux1to4_stream;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    demux1to4_stream_if #(.WIDTH(16)) bus ();

    demux1to4_stream #(.WIDTH(16), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sl(input int k);
        return bus.out_data[k*16 +: 16];
    endfunction

    task automatic push1(input logic [1:0] s, input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_sel   = s;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
`ifdef DEMUX_BCAST_EN
        bus.in_bcast  = 1'b0;
`endif
        #12;
        chk("rst_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_data", bus.out_data, 64'h0);
        chk("rst_ready", 64'(bus.in_ready), 64'h1);
        step();
        rst_n = 1'b1;
        step();

        // single word to channel 2
        push1(2'd2, 16'hA5A5);
        chk("t1_valid", 64'(bus.out_valid), 64'h4);
        chk("t1_data", bus.out_data, 64'h0000_A5A5_0000_0000);
        bus.out_ready = 4'b0100;
        step();
        bus.out_ready = 4'b0000;
        chk("t1_drain", 64'(bus.out_valid), 64'h0);

        // fill channel 1, then drain in order
        push1(2'd1, 16'h0001);
        push1(2'd1, 16'h0002);
        bus.in_sel = 2'd1;
        #1;
        chk("t2_rdy_s1", 64'(bus.in_ready), 64'h0);
        bus.in_sel = 2'd0;
        #1;
        chk("t2_rdy_s0", 64'(bus.in_ready), 64'h1);
        chk("t2_valid", 64'(bus.out_valid), 64'h2);
        bus.out_ready = 4'b0010;
        chk("t2_head0", 64'(sl(1)), 64'h0001);
        step();
        chk("t2_head1", 64'(sl(1)), 64'h0002);
        step();
        bus.out_ready = 4'b0000;
        chk("t2_empty", 64'(bus.out_valid), 64'h0);

        // full channel 3: push with simultaneous pop is refused
        push1(2'd3, 16'h0033);
        push1(2'd3, 16'h0034);
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd3;
        bus.in_data   = 16'h0003;
        bus.out_ready = 4'b1000;
        #1;
        chk("t3_refuse", 64'(bus.in_ready), 64'h0);
        step();
        bus.out_ready = 4'b0000;
        chk("t3_head", 64'(sl(3)), 64'h0034);
        chk("t3_cnt1", 64'(bus.in_ready), 64'h1);
        step();
        bus.in_valid = 1'b0;
        chk("t3_full", 64'(bus.in_ready), 64'h0);
        bus.out_ready = 4'b1000;
        chk("t3_pop0", 64'(sl(3)), 64'h0034);
        step();
        chk("t3_pop1", 64'(sl(3)), 64'h0003);
        step();
        bus.out_ready = 4'b0000;
        chk("t3_empty", 64'(bus.out_valid), 64'h0);

        // round-robin stream with every consumer ready
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'(i % 4);
            bus.in_data  = 16'(16'h10 + i);
            #1;
            chk("t4_ready", 64'(bus.in_ready), 64'h1);
            step();
            chk("t4_valid", 64'(bus.out_valid), 64'(4'b0001 << (i % 4)));
            chk("t4_data", 64'(sl(i % 4)), 64'(16'h10 + i));
        end
        bus.in_valid = 1'b0;
        step();
        chk("t4_idle", 64'(bus.out_valid), 64'h0);
        bus.out_ready = 4'b0000;

        // asynchronous reset with words buffered
        push1(2'd0, 16'h0050);
        push1(2'd2, 16'h0052);
        chk("t5_pre", 64'(bus.out_valid), 64'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(bus.out_valid), 64'h0);
        chk("t5_data", bus.out_data, 64'h0);
        chk("t5_ready", 64'(bus.in_ready), 64'h1);
        step();
        rst_n = 1'b1;
        push1(2'd1, 16'h0077);
        chk("t5_new_v", 64'(bus.out_valid), 64'h2);
        chk("t5_new_d", bus.out_data, 64'h0000_0000_0077_0000);
        bus.out_ready = 4'b0010;
        step();
        bus.out_ready = 4'b0000;

`ifdef DEMUX_BCAST_EN
        // broadcast blocked by full channel 0 until it pops
        push1(2'd0, 16'h00C0);
        push1(2'd0, 16'h00C1);
        bus.in_valid = 1'b1;
        bus.in_bcast = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 16'hBEEF;
        #1;
        chk("bc_block", 64'(bus.in_ready), 64'h0);
        bus.out_ready = 4'b0001;
        step();
        bus.out_ready = 4'b0000;
        chk("bc_open", 64'(bus.in_ready), 64'h1);
        step();
        bus.in_valid = 1'b0;
        bus.in_bcast = 1'b0;
        chk("bc_valid", 64'(bus.out_valid), 64'hF);
        chk("bc_data", bus.out_data, 64'hBEEF_BEEF_BEEF_00C1);
        bus.out_ready = 4'b1111;
        step();
        chk("bc_ch0", 64'(sl(0)), 64'hBEEF);
        chk("bc_left", 64'(bus.out_valid), 64'h1);
        step();
        bus.out_ready = 4'b0000;
        chk("bc_empty", 64'(bus.out_valid), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
